dest_reg_pipe_fwd: RTL and testbench

//   Consumer end of the EX-stage destination-register select (rt/rd mux output).

---
 rtl/dest_reg_pipe_fwd_pkg.sv | 7 +
 rtl/dest_reg_pipe_fwd_fwd_select.sv | 15 +
 rtl/dest_reg_pipe_fwd.sv | 56 +++++
 tb/tb_dest_reg_pipe_fwd.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dest_reg_pipe_fwd_pkg.sv
// dest_reg_pipe_fwd_pkg: register width and operand-forward select encodings shared with the EX operand muxes
package dest_reg_pipe_fwd_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
endpackage

// File: rtl/dest_reg_pipe_fwd_fwd_select.sv
// fwd_select: picks one ALU operand's source, with EX/MEM taking priority over MEM/WB
module fwd_select
  import dest_reg_pipe_fwd_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_regwrite,
  output logic [1:0]       sel
);
  always_comb
    sel = (mem_regwrite && mem_dest == src) ? FWD_EXMEM :
          (wb_regwrite && wb_dest == src)   ? FWD_MEMWB : FWD_REGFILE;
endmodule

// File: rtl/dest_reg_pipe_fwd.sv
// dest_reg_pipe_fwd: EX/MEM and MEM/WB dest-register latches, forwarding selects, load-use stall; FWD_STATS_EN adds a forwarding-event counter
module dest_reg_pipe_fwd
  import dest_reg_pipe_fwd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_regwrite,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] fwd_count
);
  logic mem_rw_q, wb_rw_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_dest <= '0;
      mem_rw_q <= 1'b0;
      wb_dest  <= '0;
      wb_rw_q  <= 1'b0;
    end else if (!stall) begin
      mem_dest <= ex_dest;
      mem_rw_q <= ex_regwrite & ~flush;
      wb_dest  <= mem_dest;
      wb_rw_q  <= mem_rw_q;
    end
  // r0 is hardwired zero, so a write to it is never a real write
  assign mem_regwrite = mem_rw_q & |mem_dest;
  assign wb_regwrite  = wb_rw_q & |wb_dest;
  fwd_select u_fwd_a (.src(ex_rs), .mem_dest(mem_dest), .mem_regwrite(mem_regwrite),
                      .wb_dest(wb_dest), .wb_regwrite(wb_regwrite), .sel(fwd_a));
  fwd_select u_fwd_b (.src(ex_rt), .mem_dest(mem_dest), .mem_regwrite(mem_regwrite),
                      .wb_dest(wb_dest), .wb_regwrite(wb_regwrite), .sel(fwd_b));
  assign load_use_stall = ex_memtoreg & ex_regwrite & |ex_dest &
                          (ex_dest == id_rs | ex_dest == id_rt);
`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fwd_count <= '0;
    else if (!stall && (|fwd_a || |fwd_b) && !(&fwd_count)) fwd_count <= fwd_count + 1'b1;
`else
  assign fwd_count = '0;
`endif
endmodule

// File: tb/tb_dest_reg_pipe_fwd.sv
// tb_dest_reg_pipe_fwd: directed vector table plus reset and counter sequences
module tb_dest_reg_pipe_fwd;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0] ex_dest = '0, ex_rs = '0, ex_rt = '0, id_rs = '0, id_rt = '0;
  logic ex_regwrite = 1'b0, ex_memtoreg = 1'b0;
  logic [4:0] mem_dest, wb_dest;
  logic mem_regwrite, wb_regwrite, load_use_stall;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] fwd_count;
  int n_checks = 0, n_fail = 0;

  dest_reg_pipe_fwd dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .mem_dest(mem_dest), .mem_regwrite(mem_regwrite),
    .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use_stall(load_use_stall),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, fl;
    logic [4:0] d;
    logic rw, mt;
    logic [4:0] rs, rt, irs, irt;
    logic [4:0] md;
    logic mw;
    logic [4:0] wd;
    logic ww;
    logic [1:0] fa, fb;
    logic lu;
  } vec_t;

  vec_t v[19];

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, fl, input logic [4:0] d, input logic rw, mt,
                              input logic [4:0] rs, rt, irs, irt, md, input logic mw,
                              input logic [4:0] wd, input logic ww, input logic [1:0] fa, fb,
                              input logic lu);
    vec_t r;
    r.st = st; r.fl = fl; r.d = d; r.rw = rw; r.mt = mt; r.rs = rs; r.rt = rt;
    r.irs = irs; r.irt = irt; r.md = md; r.mw = mw; r.wd = wd; r.ww = ww;
    r.fa = fa; r.fb = fb; r.lu = lu;
    return r;
  endfunction

  initial begin
    //           st fl  d rw mt rs rt irs irt  md mw wd ww  fa     fb    lu
    v[0]  = mk(0, 0, 8, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
    v[1]  = mk(0, 0, 0, 0, 0, 8, 0, 0, 0,  8, 1, 0, 0, 2'b10, 2'b00, 0);
    v[2]  = mk(0, 0, 0, 0, 0, 8, 8, 0, 0,  0, 0, 8, 1, 2'b01, 2'b01, 0);
    v[3]  = mk(0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
    v[4]  = mk(0, 0, 9, 1, 0, 0, 0, 0, 0,  9, 1, 0, 0, 2'b00, 2'b00, 0);
    v[5]  = mk(0, 0, 0, 0, 0, 0, 9, 0, 0,  9, 1, 9, 1, 2'b00, 2'b10, 0);
    v[6]  = mk(0, 0, 0, 1, 0, 0, 9, 0, 0,  0, 0, 9, 1, 2'b00, 2'b01, 0);
    v[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
    v[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0);
    v[9]  = mk(0, 0, 3, 1, 1, 0, 0, 0, 3,  0, 0, 0, 0, 2'b00, 2'b00, 1);
    v[10] = mk(0, 0, 3, 1, 1, 0, 0, 4, 4,  3, 1, 0, 0, 2'b00, 2'b00, 0);
    v[11] = mk(0, 1, 7, 1, 0, 0, 0, 0, 0,  3, 1, 3, 1, 2'b00, 2'b00, 0);
    v[12] = mk(0, 0, 0, 0, 0, 7, 3, 0, 0,  7, 0, 3, 1, 2'b00, 2'b01, 0);
    v[13] = mk(0, 0, 5, 1, 0, 7, 0, 0, 0,  0, 0, 7, 0, 2'b00, 2'b00, 0);
    v[14] = mk(1, 0, 6, 1, 0, 0, 0, 0, 0,  5, 1, 0, 0, 2'b00, 2'b00, 0);
    v[15] = mk(1, 0, 6, 1, 0, 0, 0, 0, 0,  5, 1, 0, 0, 2'b00, 2'b00, 0);
    v[16] = mk(1, 1, 6, 1, 0, 0, 0, 0, 0,  5, 1, 0, 0, 2'b00, 2'b00, 0);
    v[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 2'b00, 2'b00, 0);
    v[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 1, 2'b00, 2'b00, 0);

    #1;
    check("rst_mem_dest", 0, 16'(mem_dest), 16'd0);
    check("rst_wb_regwrite", 0, 16'(wb_regwrite), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      stall = v[i].st; flush = v[i].fl; ex_dest = v[i].d; ex_regwrite = v[i].rw;
      ex_memtoreg = v[i].mt; ex_rs = v[i].rs; ex_rt = v[i].rt; id_rs = v[i].irs; id_rt = v[i].irt;
      #1;
      check("mem_dest", i, 16'(mem_dest), 16'(v[i].md));
      check("mem_regwrite", i, 16'(mem_regwrite), 16'(v[i].mw));
      check("wb_dest", i, 16'(wb_dest), 16'(v[i].wd));
      check("wb_regwrite", i, 16'(wb_regwrite), 16'(v[i].ww));
      check("fwd_a", i, 16'(fwd_a), 16'(v[i].fa));
      check("fwd_b", i, 16'(fwd_b), 16'(v[i].fb));
      check("load_use_stall", i, 16'(load_use_stall), 16'(v[i].lu));
      @(posedge clk); #1;
      if (i == 2) begin
`ifdef FWD_STATS_EN
        check("fwd_count", i, fwd_count, 16'd2);
`else
        check("fwd_count", i, fwd_count, 16'd0);
`endif
      end
    end

    // mid-cycle reset with a live write sitting in EX/MEM
    stall = 1'b0; flush = 1'b0; ex_dest = 5'd5; ex_regwrite = 1'b1; ex_memtoreg = 1'b0;
    ex_rs = 5'd5; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    @(posedge clk); #1;
    check("pre_rst_mem_dest", 0, 16'(mem_dest), 16'd5);
    check("pre_rst_fwd_a", 0, 16'(fwd_a), 16'b10);
    #2 rst_n = 1'b0; #1;
    check("async_rst_mem_dest", 0, 16'(mem_dest), 16'd0);
    check("async_rst_mem_regwrite", 0, 16'(mem_regwrite), 16'd0);
    check("async_rst_wb_regwrite", 0, 16'(wb_regwrite), 16'd0);
    check("async_rst_fwd_a", 0, 16'(fwd_a), 16'd0);
    check("async_rst_fwd_count", 0, fwd_count, 16'd0);
    @(posedge clk); #1;
    check("held_rst_wb_dest", 0, 16'(wb_dest), 16'd0);
    check("held_rst_mem_regwrite", 0, 16'(mem_regwrite), 16'd0);
    ex_regwrite = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_wb_regwrite", 0, 16'(wb_regwrite), 16'd0);
    check("post_rst_mem_regwrite", 0, 16'(mem_regwrite), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
